// File: rtl/pulse_cascade_gen_pkg.sv
// Shared types and parameter limits for the pulse cascade generator.
// The run-control state and the legal parameter ranges live here so all files agree.
package pulse_cascade_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  localparam int DIV_MIN    = 2;
  localparam int DIV_MAX    = 1 << 24;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 6;
  localparam int BASE_MIN   = 2;
  localparam int BASE_MAX   = 16;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous clear (dominant), count enable and
// a combinational carry that is high on the enabled edge where the count wraps.
module mod_counter #(
  parameter int MOD = 10
) (
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic carry_o
);

  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

  logic [CW-1:0] count_q, count_d;

  assign carry_o = en_i && (count_q == CW'(MOD - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = carry_o ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/pulse_cascade_gen.sv
// Prescaled base tick followed by a chain of divide-by-BASE stages, with
// run/pause/idle control and an optional one-shot stop after the last stage wraps.
module pulse_cascade_gen
  import pulse_cascade_gen_pkg::*;
#(
  parameter int DIV    = 50000,
  parameter int STAGES = 3,
  parameter int BASE   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  output logic [STAGES:0]   tick,
  output logic              running,
  output logic              done
);

  localparam int PW = $clog2(DIV);

  state_e          state_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic [STAGES:0] evt;
  logic [STAGES:0] tick_q;
  logic            running_q;
  logic            done_q;
  logic            advance;
  logic            finish;
  logic            ctr_clr;

  // Stop on the sampling edge freezes everything, so no tick can leave that edge.
  assign advance = (state_q == ST_RUN) && !stop && !reset;
  assign evt[0]  = advance && (pre_q == PW'(DIV - 1));
  assign finish  = oneshot && evt[STAGES];
  assign ctr_clr = reset || finish || (state_q == ST_IDLE);

  always_comb begin
    pre_d = pre_q;
    if (reset || finish) begin
      pre_d = '0;
    end else if (advance) begin
      pre_d = evt[0] ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    pre_q <= pre_d;
  end

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      mod_counter #(
        .MOD(BASE)
      ) u_stage (
        .clk    (clk),
        .clr_i  (ctr_clr),
        .en_i   (evt[gi-1]),
        .carry_o(evt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
    end else begin
      tick_q <= evt;
      done_q <= finish;
      unique case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (start && !stop) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q   <= ST_PAUSED;
            running_q <= 1'b0;
          end else if (finish) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pulse_cascade_gen.sv
// Scoreboard bench for pulse_cascade_gen (DIV=4, BASE=10): two instances,
// STAGES=2 free-running and STAGES=1 one-shot, with expected tick events queued per edge.
module tb_pulse_cascade_gen;

  typedef struct {
    int         edge_n;
    logic [2:0] tick;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic       r2, st2, sp2, os2;
  logic [2:0] tick2;
  logic       running2, done2;
  logic       r1, st1, sp1, os1;
  logic [1:0] tick1;
  logic       running1, done1;

  pulse_cascade_gen #(.DIV(4), .STAGES(2), .BASE(10)) dut2 (
    .clk(clk), .reset(r2), .start(st2), .stop(sp2), .oneshot(os2),
    .tick(tick2), .running(running2), .done(done2)
  );

  pulse_cascade_gen #(.DIV(4), .STAGES(1), .BASE(10)) dut1 (
    .clk(clk), .reset(r1), .start(st1), .stop(sp1), .oneshot(os1),
    .tick(tick1), .running(running1), .done(done1)
  );

  exp_t q2[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t mk(input int e, input logic [2:0] t, input logic d);
    exp_t x;
    x.edge_n = e;
    x.tick   = t;
    x.done   = d;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_cnt, act, exp);
    end
  endtask

  task automatic goto(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Monitor: every cycle presenting a tick or done is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (tick2 !== 3'b000 || done2 !== 1'b0) begin
          n_cmp++;
          if (q2.size() == 0) begin
            n_bad++;
            $display("FAIL dut2_unexpected: edge %0d tick %b done %b, no event expected",
                     edge_cnt, tick2, done2);
          end else begin
            e = q2.pop_front();
            if (e.edge_n != edge_cnt || e.tick !== tick2 || e.done !== done2) begin
              n_bad++;
              $display("FAIL dut2_event: edge %0d tick %b done %b, expected edge %0d tick %b done %b",
                       edge_cnt, tick2, done2, e.edge_n, e.tick, e.done);
            end else begin
              $display("dut2 edge=%0d tick=%b done=%b ok", edge_cnt, tick2, done2);
            end
          end
        end
        if (tick1 !== 2'b00 || done1 !== 1'b0) begin
          n_cmp++;
          if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL dut1_unexpected: edge %0d tick %b done %b, no event expected",
                     edge_cnt, tick1, done1);
          end else begin
            e = q1.pop_front();
            if (e.edge_n != edge_cnt || e.tick !== {1'b0, tick1} || e.done !== done1) begin
              n_bad++;
              $display("FAIL dut1_event: edge %0d tick %b done %b, expected edge %0d tick %b done %b",
                       edge_cnt, tick1, done1, e.edge_n, e.tick[1:0], e.done);
            end else begin
              $display("dut1 edge=%0d tick=%b done=%b ok", edge_cnt, tick1, done1);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s2;
    int rr;
    r2 = 1'b1; st2 = 1'b0; sp2 = 1'b0; os2 = 1'b0;
    r1 = 1'b1; st1 = 1'b0; sp1 = 1'b0; os1 = 1'b1;
    @(negedge clk);
    goto(3);
    r2 = 1'b0; r1 = 1'b0;
    mon_en = 1'b1;
    chk("reset_tick2", 32'(tick2), 0);
    chk("reset_running2", 32'(running2), 0);
    chk("reset_done2", 32'(done2), 0);
    chk("reset_tick1", 32'(tick1), 0);
    chk("reset_running1", 32'(running1), 0);
    chk("reset_done1", 32'(done1), 0);

    // Free-run cascade: base every 4 edges, stage 1 every 40, stage 2 every 400.
    s = edge_cnt + 1;
    st2 = 1'b1;
    for (int k = 1; k <= 100; k++)
      q2.push_back(mk(s + 4*k, {(k % 100 == 0), (k % 10 == 0), 1'b1}, 1'b0));
    goto(s);
    st2 = 1'b0;
    chk("freerun_running_after_start", 32'(running2), 1);
    goto(s + 401);
    chk("freerun_running_late", 32'(running2), 1);
    r2 = 1'b1;
    goto(s + 402);
    r2 = 1'b0;
    chk("freerun_reset_running", 32'(running2), 0);

    // Pause at +6, resume at +20: held phase gives ticks at +4 and +23 only.
    s = edge_cnt + 1;
    st2 = 1'b1;
    q2.push_back(mk(s + 4, 3'b001, 1'b0));
    q2.push_back(mk(s + 23, 3'b001, 1'b0));
    goto(s);
    st2 = 1'b0;
    chk("pause_running_start", 32'(running2), 1);
    goto(s + 5);
    sp2 = 1'b1;
    goto(s + 6);
    sp2 = 1'b0;
    chk("pause_running_paused", 32'(running2), 0);
    goto(s + 19);
    st2 = 1'b1;
    goto(s + 20);
    st2 = 1'b0;
    chk("pause_running_resumed", 32'(running2), 1);
    goto(s + 25);
    r2 = 1'b1;
    goto(s + 26);
    r2 = 1'b0;
    chk("pause_reset_tick", 32'(tick2), 0);
    chk("pause_reset_running", 32'(running2), 0);

    // start and stop together: RUN goes to PAUSED, IDLE stays IDLE.
    s = edge_cnt + 1;
    st2 = 1'b1;
    q2.push_back(mk(s + 4, 3'b001, 1'b0));
    goto(s);
    st2 = 1'b0;
    goto(s + 5);
    st2 = 1'b1; sp2 = 1'b1;
    goto(s + 6);
    st2 = 1'b0; sp2 = 1'b0;
    chk("both_in_run_running", 32'(running2), 0);
    goto(s + 20);
    r2 = 1'b1;
    rr = edge_cnt + 1;
    goto(rr);
    r2 = 1'b0;
    st2 = 1'b1; sp2 = 1'b1;
    goto(rr + 3);
    chk("both_in_idle_running", 32'(running2), 0);
    goto(rr + 15);
    st2 = 1'b0; sp2 = 1'b0;
    chk("both_in_idle_running_late", 32'(running2), 0);

    // One-shot, STAGES=1: ends at +40 with tick=11 and done, then stays idle.
    s = edge_cnt + 1;
    st1 = 1'b1;
    for (int k = 1; k <= 10; k++)
      q1.push_back(mk(s + 4*k, {1'b0, (k == 10), 1'b1}, (k == 10)));
    goto(s);
    st1 = 1'b0;
    chk("oneshot_running_start", 32'(running1), 1);
    goto(s + 40);
    chk("oneshot_done_pulse", 32'(done1), 1);
    chk("oneshot_running_end", 32'(running1), 0);
    goto(s + 41);
    chk("oneshot_done_single", 32'(done1), 0);
    chk("oneshot_running_after", 32'(running1), 0);
    goto(s + 60);
    // A fresh start from IDLE begins from zero counts.
    s2 = edge_cnt + 1;
    st1 = 1'b1;
    q1.push_back(mk(s2 + 4, 3'b001, 1'b0));
    goto(s2);
    st1 = 1'b0;
    goto(s2 + 5);
    r1 = 1'b1;
    goto(s2 + 6);
    r1 = 1'b0;
    chk("oneshot_restart_reset_running", 32'(running1), 0);

    // Reset mid-run at +10 discards the count; restart at +12 ticks at +16.
    s = edge_cnt + 1;
    st2 = 1'b1;
    q2.push_back(mk(s + 4, 3'b001, 1'b0));
    q2.push_back(mk(s + 8, 3'b001, 1'b0));
    q2.push_back(mk(s + 16, 3'b001, 1'b0));
    goto(s);
    st2 = 1'b0;
    goto(s + 9);
    r2 = 1'b1;
    goto(s + 10);
    r2 = 1'b0;
    chk("midreset_tick", 32'(tick2), 0);
    chk("midreset_running", 32'(running2), 0);
    chk("midreset_done", 32'(done2), 0);
    goto(s + 11);
    st2 = 1'b1;
    goto(s + 12);
    st2 = 1'b0;
    chk("midreset_restart_running", 32'(running2), 1);
    goto(s + 18);
    r2 = 1'b1;
    goto(s + 19);
    r2 = 1'b0;

    goto(edge_cnt + 10);
    chk("dut2_events_pending", 32'(q2.size()), 0);
    chk("dut1_events_pending", 32'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_cascade_gen.md
PULSE_CASCADE_GEN -- requirements
Module: pulse_cascade_gen

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the clock cycles per base tick; legal range 2..2^24.
REQ-002 Parameter STAGES, default 3, SHALL set the number of cascaded divide-by-BASE stages after the base tick; legal range 1..6.
REQ-003 Parameter BASE, default 10, SHALL set the modulus of every cascaded stage; legal range 2..16.
REQ-004 Port clk, input, 1, SHALL be the single clock; one clock, all logic on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the reset: synchronous, active-high.
REQ-006 Port start, input, 1, SHALL be the level-sampled run request.
REQ-007 Port stop, input, 1, SHALL be the level-sampled pause request.
REQ-008 Port oneshot, input, 1, SHALL select auto-stop after one full wrap of the last stage when high, and free-run when low.
REQ-009 Port tick, output, STAGES+1, SHALL carry single-cycle pulses: bit 0 is the base tick, bit i is the carry of stage i.
REQ-010 Port running, output, 1, SHALL be high while the state is RUN.
REQ-011 Port done, output, 1, SHALL pulse for one cycle when a oneshot run completes.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and PAUSED.
REQ-013 IDLE and PAUSED SHALL go to RUN on an edge where start=1 and stop=0.
REQ-014 RUN SHALL go to PAUSED on any edge where stop=1; stop SHALL win over a simultaneous start in every state.
REQ-015 The prescaler (width clog2(DIV)) SHALL advance only on edges where the pre-edge state is RUN and stop=0; at count DIV-1 it SHALL wrap to 0.
REQ-016 tick[0] SHALL be registered and high for exactly the one cycle following a prescaler wrap edge; first pulse follows the DIV-th edge after the start-sampling edge.
REQ-017 Stage i (count 0..BASE-1) SHALL advance on edges where tick[i-1] is generated; on wrap, tick[i] SHALL be asserted in the same cycle as tick[i-1].
REQ-018 PAUSED SHALL hold the prescaler and all stage counts; resume SHALL continue from the held phase without restart.
REQ-019 No tick bit SHALL assert on the edge that samples stop or in any non-RUN cycle.
REQ-020 With oneshot=1, on the edge where the last stage wraps, ticks SHALL be emitted, done SHALL pulse, the state SHALL go to IDLE, and all counters SHALL clear.
REQ-021 A start from IDLE SHALL always begin from zero counts.
REQ-022 oneshot SHALL be sampled continuously; changing it mid-run SHALL take effect at the next last-stage wrap.

Reset
REQ-023 reset=1 on an edge SHALL force IDLE, prescaler=0, all stages=0, tick=0, running=0 and done=0, overriding start and stop.
REQ-024 Reset mid-RUN SHALL discard the partial count; no tick or done SHALL be generated at that edge.

Structure
REQ-025 A shared package SHALL hold the state enum typedef (IDLE/RUN/PAUSED) and the parameter legal-range constants.
REQ-026 One sub-module, mod_counter (modulo-BASE counter with enable, clear and carry-out), SHALL be instantiated STAGES times in a generate loop.

Verification (DIV=4, BASE=10)
REQ-027 Bench SHALL cover, STAGES=2, reset then start at edge 0: running=1 after edge 0; tick[0] after edges 4, 8, 12, ...
REQ-028 Bench SHALL cover, same setup, free-run: tick[1] first after edge 40; tick[2] first after edge 400, coincident with tick[0] and tick[1].
REQ-029 Bench SHALL cover pause/resume: start at edge 0, stop at edge 6, start at edge 20 -> ticks after edges 4 and 23 only, none between.
REQ-030 Bench SHALL cover simultaneous events: start=stop=1 in RUN -> PAUSED; start=stop=1 in IDLE -> stays IDLE, no ticks.
REQ-031 Bench SHALL cover oneshot, STAGES=1: start at edge 0 -> tick[1:0]=11 and done=1 after edge 40; running=0 thereafter; no further ticks.
REQ-032 Bench SHALL cover reset mid-run: reset at edge 10 -> all outputs 0 after edge 10; start at edge 12 -> first tick after edge 16.
